// File: rtl/tucanos_pkg.sv
// Shared encodings for the Tucanos process scheduler: event codes,
// per-process status values and scheduler FSM states.
package tucanos_pkg;

  localparam logic [11:0] OPERATING_SYSTEM_BEGIN_ADDR = 12'd256;

  typedef enum logic [1:0] {
    EV_PREEMPT = 2'd0,
    EV_WAIT    = 2'd1,
    EV_HALT    = 2'd2,
    EV_RSVD    = 2'd3
  } event_code_e;

  typedef enum logic [2:0] {
    ST_EMPTY   = 3'd0,
    ST_READY   = 3'd1,
    ST_RUNNING = 3'd2,
    ST_WAITING = 3'd3,
    ST_HALTED  = 3'd4
  } proc_status_e;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SELECT   = 3'd1,
    S_DISPATCH = 3'd2,
    S_RUNNING  = 3'd3,
    S_STALL    = 3'd4,
    S_DONE     = 3'd5
  } sched_state_e;

endpackage

// File: rtl/tucanos_rr_picker.sv
// Rotating-priority search: first set bit of mask at or after start,
// wrapping modulo N.
module tucanos_rr_picker #(
  parameter int N = 3,
  parameter int W = 2
) (
  input  logic [N-1:0] mask,
  input  logic [W-1:0] start,
  output logic         found,
  output logic [W-1:0] index
);

  always_comb begin
    int p;
    found = 1'b0;
    index = '0;
    // Walk from the farthest offset back to zero so the nearest hit wins.
    for (int k = N - 1; k >= 0; k--) begin
      p = int'(start) + k;
      if (p >= N) p = p - N;
      if (p < N && mask[p]) begin
        found = 1'b1;
        index = W'(p);
      end
    end
  end

endmodule

// File: rtl/tucanos_process_scheduler.sv
// Round-robin process scheduler: status/saved-PC table, scheduling FSM and
// valid/ready dispatch offer towards the OS context-switch routine.
module tucanos_process_scheduler
  import tucanos_pkg::*;
#(
  parameter int                 NUM_PROCS   = 3,
  parameter int                 IDX_WIDTH   = 2,
  parameter int                 PC_WIDTH    = 12,
  parameter logic [PC_WIDTH-1:0] PROC_BASE   = 12'd1024,
  parameter logic [PC_WIDTH-1:0] PROC_STRIDE = 12'd1024
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 event_valid,
  input  logic [1:0]           event_code,
  input  logic [PC_WIDTH-1:0]  event_pc,
  input  logic                 io_done_valid,
  input  logic [IDX_WIDTH-1:0] io_done_index,
  input  logic                 dispatch_ready,
  output logic                 dispatch_valid,
  output logic [IDX_WIDTH-1:0] dispatch_index,
  output logic [PC_WIDTH-1:0]  dispatch_pc,
  output logic [IDX_WIDTH-1:0] current_index,
  output logic                 stalled,
  output logic                 all_halted,
  output logic                 event_dropped
);

  localparam logic [IDX_WIDTH-1:0] LAST_IDX  = IDX_WIDTH'(NUM_PROCS - 1);
  localparam logic [IDX_WIDTH:0]   NUM_IDX_W = (IDX_WIDTH + 1)'(NUM_PROCS);

  sched_state_e          state_reg, state_next;
  proc_status_e          status_reg [NUM_PROCS];
  logic [PC_WIDTH-1:0]   saved_pc_reg [NUM_PROCS];
  logic [IDX_WIDTH-1:0]  cur_reg, disp_idx_reg;
  logic [PC_WIDTH-1:0]   disp_pc_reg;
  logic                  dropped_reg;

  logic [NUM_PROCS-1:0]  ready_mask, halted_mask;
  logic [IDX_WIDTH-1:0]  scan_start, pick_index;
  logic                  pick_found;
  logic                  launch, ev_take, io_hit, handshake;

  for (genvar gi = 0; gi < NUM_PROCS; gi++) begin : g_mask
    assign ready_mask[gi]  = (status_reg[gi] == ST_READY);
    assign halted_mask[gi] = (status_reg[gi] == ST_HALTED);
  end

  assign scan_start = (cur_reg == LAST_IDX) ? '0 : cur_reg + 1'b1;

  tucanos_rr_picker #(.N(NUM_PROCS), .W(IDX_WIDTH)) u_picker (
    .mask  (ready_mask),
    .start (scan_start),
    .found (pick_found),
    .index (pick_index)
  );

  assign launch    = start && (state_reg == S_IDLE || state_reg == S_DONE);
  assign ev_take   = event_valid && (state_reg == S_RUNNING) &&
                     (event_code_e'(event_code) != EV_RSVD);
  assign io_hit    = io_done_valid && ({1'b0, io_done_index} < NUM_IDX_W);
  assign handshake = (state_reg == S_DISPATCH) && dispatch_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_reg <= S_IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE, S_DONE: if (start) state_next = S_SELECT;
      S_RUNNING:      if (ev_take) state_next = S_SELECT;
      S_SELECT: begin
        if (pick_found)         state_next = S_DISPATCH;
        else if (&halted_mask)  state_next = S_DONE;
        else                    state_next = S_STALL;
      end
      S_STALL:        if (|ready_mask) state_next = S_SELECT;
      S_DISPATCH:     if (dispatch_ready) state_next = S_RUNNING;
      default:        state_next = S_IDLE;
    endcase
  end

  // io_done is judged against the pre-edge status; a same-cycle event on the
  // running process therefore always wins over it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_PROCS; i++) begin
        status_reg[i]   <= ST_EMPTY;
        saved_pc_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_PROCS; i++) begin
        if (launch) begin
          status_reg[i]   <= ST_READY;
          saved_pc_reg[i] <= PROC_BASE + PC_WIDTH'(i) * PROC_STRIDE;
        end else if (ev_take && cur_reg == IDX_WIDTH'(i)) begin
          case (event_code_e'(event_code))
            EV_PREEMPT: begin
              status_reg[i]   <= ST_READY;
              saved_pc_reg[i] <= event_pc;
            end
            EV_WAIT: begin
              status_reg[i]   <= ST_WAITING;
              saved_pc_reg[i] <= event_pc;
            end
            default: status_reg[i] <= ST_HALTED;
          endcase
        end else if (handshake && disp_idx_reg == IDX_WIDTH'(i)) begin
          status_reg[i] <= ST_RUNNING;
        end else if (io_hit && io_done_index == IDX_WIDTH'(i) &&
                     status_reg[i] == ST_WAITING) begin
          status_reg[i] <= ST_READY;
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cur_reg      <= '0;
      disp_idx_reg <= '0;
      disp_pc_reg  <= '0;
      dropped_reg  <= 1'b0;
    end else begin
      if (launch) begin
        cur_reg     <= LAST_IDX;
        dropped_reg <= 1'b0;
      end
      if (state_reg == S_SELECT && pick_found) begin
        disp_idx_reg <= pick_index;
        disp_pc_reg  <= saved_pc_reg[pick_index];
      end
      if (handshake) cur_reg <= disp_idx_reg;
      if (event_valid && state_reg != S_RUNNING) dropped_reg <= 1'b1;
    end
  end

  assign dispatch_valid = (state_reg == S_DISPATCH);
  assign dispatch_index = disp_idx_reg;
  assign dispatch_pc    = disp_pc_reg;
  assign current_index  = cur_reg;
  assign stalled        = (state_reg == S_STALL);
  assign all_halted     = (state_reg == S_DONE);
  assign event_dropped  = dropped_reg;

endmodule

// File: tb/tb_tucanos_process_scheduler.sv
// Directed bench for tucanos_process_scheduler: a dispatch-order vector table
// followed by hand-written wait/stall, halt, backpressure and reset sequences.
module tb_tucanos_process_scheduler;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        event_valid;
  logic [1:0]  event_code;
  logic [11:0] event_pc;
  logic        io_done_valid;
  logic [1:0]  io_done_index;
  logic        dispatch_ready;
  logic        dispatch_valid;
  logic [1:0]  dispatch_index;
  logic [11:0] dispatch_pc;
  logic [1:0]  current_index;
  logic        stalled;
  logic        all_halted;
  logic        event_dropped;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  tucanos_process_scheduler dut (
    .clock          (clock),
    .reset          (reset),
    .start          (start),
    .event_valid    (event_valid),
    .event_code     (event_code),
    .event_pc       (event_pc),
    .io_done_valid  (io_done_valid),
    .io_done_index  (io_done_index),
    .dispatch_ready (dispatch_ready),
    .dispatch_valid (dispatch_valid),
    .dispatch_index (dispatch_index),
    .dispatch_pc    (dispatch_pc),
    .current_index  (current_index),
    .stalled        (stalled),
    .all_halted     (all_halted),
    .event_dropped  (event_dropped)
  );

  typedef struct {
    logic        do_start;
    logic [1:0]  code;
    logic [11:0] pc;
    logic [1:0]  exp_idx;
    logic [11:0] exp_pc;
  } vec_t;

  vec_t vecs [7];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_event(input logic [1:0] code, input logic [11:0] pc);
    event_valid = 1'b1;
    event_code  = code;
    event_pc    = pc;
    tick();
    event_valid = 1'b0;
  endtask

  task automatic send_io(input logic [1:0] idx);
    io_done_valid = 1'b1;
    io_done_index = idx;
    tick();
    io_done_valid = 1'b0;
  endtask

  task automatic wait_offer(input string name);
    int n = 0;
    while (!dispatch_valid && n < 20) begin
      tick();
      n++;
    end
    check({name, "_offer"}, int'(dispatch_valid), 1);
  endtask

  task automatic take(input string name, input logic [1:0] idx, input logic [11:0] pc);
    wait_offer(name);
    check({name, "_idx"}, int'(dispatch_index), int'(idx));
    check({name, "_pc"}, int'(dispatch_pc), int'(pc));
    dispatch_ready = 1'b1;
    tick();
    dispatch_ready = 1'b0;
    check({name, "_cur"}, int'(current_index), int'(idx));
    check({name, "_vdrop"}, int'(dispatch_valid), 0);
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, "_valid"}, int'(dispatch_valid), 0);
    check({name, "_idx"}, int'(dispatch_index), 0);
    check({name, "_pc"}, int'(dispatch_pc), 0);
    check({name, "_cur"}, int'(current_index), 0);
    check({name, "_stalled"}, int'(stalled), 0);
    check({name, "_halted"}, int'(all_halted), 0);
    check({name, "_dropped"}, int'(event_dropped), 0);
  endtask

  initial begin
    bit hold_ok;
    vecs[0] = '{1'b1, 2'd0, 12'd0,    2'd0, 12'd1024};
    vecs[1] = '{1'b0, 2'd0, 12'd1030, 2'd1, 12'd2048};
    vecs[2] = '{1'b0, 2'd0, 12'd2050, 2'd2, 12'd3072};
    vecs[3] = '{1'b0, 2'd0, 12'd3080, 2'd0, 12'd1030};
    vecs[4] = '{1'b0, 2'd0, 12'd1031, 2'd1, 12'd2050};
    vecs[5] = '{1'b0, 2'd1, 12'd2060, 2'd2, 12'd3080};
    vecs[6] = '{1'b0, 2'd0, 12'd3090, 2'd0, 12'd1031};

    reset = 1'b1; start = 1'b0; event_valid = 1'b0; event_code = 2'd0;
    event_pc = '0; io_done_valid = 1'b0; io_done_index = '0; dispatch_ready = 1'b0;
    #1;
    check_idle_outputs("reset");
    tick(); tick();
    @(negedge clock);
    reset = 1'b0;
    tick();

    // Round-robin dispatch order with preempt/wait events.
    for (int i = 0; i < 7; i++) begin
      if (vecs[i].do_start) begin
        pulse_start();
      end else begin
        send_event(vecs[i].code, vecs[i].pc);
        check($sformatf("v%0d_lat_sel", i), int'(dispatch_valid), 0);
        tick();
        check($sformatf("v%0d_lat_disp", i), int'(dispatch_valid), 1);
      end
      take($sformatf("v%0d", i), vecs[i].exp_idx, vecs[i].exp_pc);
    end

    // Reset while an offer is pending.
    send_event(2'd0, 12'd1032);
    wait_offer("rst_pre");
    check("rst_pre_idx", int'(dispatch_index), 2);
    check("rst_pre_pc", int'(dispatch_pc), 3090);
    #2 reset = 1'b1;
    #1;
    check_idle_outputs("rst_mid");
    @(negedge clock);
    reset = 1'b0;
    tick(); tick();
    check("idle_no_offer", int'(dispatch_valid), 0);
    send_event(2'd0, 12'd5);
    check("idle_dropped", int'(event_dropped), 1);
    check("idle_no_offer2", int'(dispatch_valid), 0);

    // All processes wait -> stall; io_done releases one.
    pulse_start();
    check("start_clears_dropped", int'(event_dropped), 0);
    take("w0", 2'd0, 12'd1024);
    send_event(2'd1, 12'd1040);
    take("w1", 2'd1, 12'd2048);
    send_event(2'd1, 12'd2100);
    take("w2", 2'd2, 12'd3072);
    send_event(2'd1, 12'd3100);
    tick();
    check("stall_set", int'(stalled), 1);
    check("stall_no_offer", int'(dispatch_valid), 0);
    send_io(2'd3);
    tick(); tick();
    check("stall_bad_io_idx", int'(stalled), 1);
    send_io(2'd1);
    take("io1", 2'd1, 12'd2100);
    check("io1_unstalled", int'(stalled), 0);

    // io_done for a running process, and together with its own WAIT, is ignored.
    send_io(2'd1);
    event_valid = 1'b1; event_code = 2'd1; event_pc = 12'd2210;
    io_done_valid = 1'b1; io_done_index = 2'd1;
    tick();
    event_valid = 1'b0; io_done_valid = 1'b0;
    tick(); tick();
    check("wait_io_same_stalled", int'(stalled), 1);
    check("wait_io_same_no_offer", int'(dispatch_valid), 0);

    // Event during DISPATCH is dropped and leaves the table alone.
    send_io(2'd0);
    wait_offer("drop");
    send_event(2'd0, 12'd999);
    check("drop_flag", int'(event_dropped), 1);
    check("drop_valid", int'(dispatch_valid), 1);
    take("drop", 2'd0, 12'd1040);
    send_event(2'd0, 12'd1050);
    take("after_drop", 2'd0, 12'd1050);

    // Halt every process in turn.
    send_event(2'd2, 12'd0);
    tick();
    check("h0_stalled", int'(stalled), 1);
    check("h0_not_done", int'(all_halted), 0);
    send_io(2'd1);
    take("h1", 2'd1, 12'd2210);
    send_event(2'd2, 12'd0);
    tick();
    send_io(2'd2);
    take("h2", 2'd2, 12'd3100);
    send_event(2'd2, 12'd0);
    tick();
    check("done_halted", int'(all_halted), 1);
    check("done_no_offer", int'(dispatch_valid), 0);
    check("done_not_stalled", int'(stalled), 0);
    tick();
    check("done_hold", int'(all_halted), 1);

    // Restart and hold off the dispatch for five cycles.
    pulse_start();
    wait_offer("bp");
    check("bp_halted_clr", int'(all_halted), 0);
    hold_ok = 1'b1;
    for (int c = 0; c < 5; c++) begin
      if (!dispatch_valid || dispatch_index != 2'd0 || dispatch_pc != 12'd1024)
        hold_ok = 1'b0;
      tick();
    end
    check("bp_stable", int'(hold_ok), 1);
    check("bp_pc", int'(dispatch_pc), 1024);
    dispatch_ready = 1'b1;
    tick();
    dispatch_ready = 1'b0;
    check("bp_accept_valid", int'(dispatch_valid), 0);
    check("bp_accept_cur", int'(current_index), 0);

    // Reserved event code keeps the process running.
    send_event(2'd3, 12'd123);
    tick(); tick();
    check("rsvd_no_offer", int'(dispatch_valid), 0);
    check("rsvd_not_dropped", int'(event_dropped), 0);
    send_event(2'd0, 12'd1060);
    take("rsvd_after", 2'd1, 12'd2048);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
